// File: rtl/sccb_arbiter.sv
// Two-requester round-robin arbiter in front of an SCCB master: it latches the
// winner's id/addr/data, pulses start_tx, waits for finish or timeout, acks the owner, then idles for a gap.
module sccb_arbiter #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] id0,
  input  logic [6:0] id1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       err,
  input  logic       sccb_ready,
  input  logic       sccb_finish,
  output logic       start_tx,
  output logic [6:0] id,
  output logic [7:0] addr,
  output logic [7:0] data_wr,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, ACK, GAP} state_t;

  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        owner_q, owner_d;
  logic [6:0]  id_q, id_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        grant_sel;
  logic [16:0] wait_cnt;

  // On a tie the requester that did not win last time gets the grant.
  assign grant_sel = (req0 && req1) ? ~owner_q : req1;
  // WAIT_DONE counts from 1 while the register was cleared on entry.
  assign wait_cnt  = {1'b0, cnt_q} + 17'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      owner_q <= 1'b1;
      id_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      owner_q <= owner_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    owner_d = owner_q;
    id_d    = id_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (sccb_ready && (req0 || req1)) begin
          owner_d = grant_sel;
          id_d    = grant_sel ? id1   : id0;
          addr_d  = grant_sel ? addr1 : addr0;
          data_d  = grant_sel ? data1 : data0;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Finish takes priority over a coincident timeout.
        if (sccb_finish) begin
          err_d   = 1'b0;
          state_d = ACK;
        end else if (wait_cnt >= TIMEOUT_LIM) begin
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ACK: begin
        cnt_d   = '0;
        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_tx = (state_q == START);
  assign ack0     = (state_q == ACK) && !owner_q;
  assign ack1     = (state_q == ACK) && owner_q;
  assign err      = (state_q == ACK) && err_q;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;
  assign id       = id_q;
  assign addr     = addr_q;
  assign data_wr  = data_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Bench for sccb_arbiter: two instances (gap 16 and gap 0) share stimulus; a
// transaction-timeline model feeds scoreboard queues checked by a negedge monitor.
module tb_sccb_arbiter;

  localparam int TO = 100;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req0, req1, sccb_ready, sccb_finish;
  logic [6:0] id0, id1;
  logic [7:0] addr0, addr1, data0, data1;

  logic       a_ack0, a_ack1, a_err, a_start, a_busy, a_owner;
  logic [6:0] a_id;
  logic [7:0] a_addr, a_data;
  logic       b_ack0, b_ack1, b_err, b_start, b_busy, b_owner;
  logic [6:0] b_id;
  logic [7:0] b_addr, b_data;

  sccb_arbiter #(.GAP_CYCLES(16), .TIMEOUT_CYCLES(TO)) u_dut_a (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .id0(id0), .id1(id1), .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .ack0(a_ack0), .ack1(a_ack1), .err(a_err),
    .sccb_ready(sccb_ready), .sccb_finish(sccb_finish), .start_tx(a_start),
    .id(a_id), .addr(a_addr), .data_wr(a_data), .busy(a_busy), .owner(a_owner)
  );

  sccb_arbiter #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) u_dut_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .id0(id0), .id1(id1), .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .ack0(b_ack0), .ack1(b_ack1), .err(b_err),
    .sccb_ready(sccb_ready), .sccb_finish(sccb_finish), .start_tx(b_start),
    .id(b_id), .addr(b_addr), .data_wr(b_data), .busy(b_busy), .owner(b_owner)
  );

  logic       sel = 1'b0;
  logic       s_ack0, s_ack1, s_err, s_start, s_busy, s_owner;
  logic [6:0] s_id;
  logic [7:0] s_addr, s_data;
  assign s_ack0  = sel ? b_ack0  : a_ack0;
  assign s_ack1  = sel ? b_ack1  : a_ack1;
  assign s_err   = sel ? b_err   : a_err;
  assign s_start = sel ? b_start : a_start;
  assign s_busy  = sel ? b_busy  : a_busy;
  assign s_owner = sel ? b_owner : a_owner;
  assign s_id    = sel ? b_id    : a_id;
  assign s_addr  = sel ? b_addr  : a_addr;
  assign s_data  = sel ? b_data  : a_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct packed { logic [6:0] id; logic [7:0] addr; logic [7:0] data; logic own; } txn_t;
  typedef struct packed { logic own; logic err; } ack_t;
  txn_t txq[$];
  ack_t ackq[$];

  // Model: a transaction granted in cycle g starts at g+1; its outcome is fixed
  // by the first finish after the start cycle or by reaching TO waiting cycles;
  // the arbiter may grant again from ack+1+gap.
  bit         mon_en = 1'b0;
  bit         m_in_txn, m_decided, m_owner;
  int         m_start, m_ack, idle_from;
  logic [6:0] m_id;
  logic [7:0] m_addr, m_data;

  always @(negedge clk) begin
    int   gapv;
    bit   exp_start, exp_ack, g;
    txn_t t;
    ack_t a;
    gapv = sel ? 0 : 16;
    if (rst) begin
      mon_en    = 1'b1;
      m_in_txn  = 1'b0;
      m_decided = 1'b0;
      m_owner   = 1'b1;
      m_id      = '0;
      m_addr    = '0;
      m_data    = '0;
      idle_from = cyc + 1;
      txq.delete();
      ackq.delete();
    end else if (mon_en) begin
      exp_start = m_in_txn && (cyc == m_start);
      exp_ack   = m_in_txn && m_decided && (cyc == m_ack);
      chk("start_tx", s_start, exp_start);
      if ((s_start || exp_start) && txq.size() != 0) begin
        t = txq.pop_front();
        if (s_start) begin
          chk("grant_id", s_id, t.id);
          chk("grant_addr", s_addr, t.addr);
          chk("grant_data", s_data, t.data);
          chk("grant_owner", s_owner, t.own);
        end
      end
      if (s_ack0 || s_ack1 || exp_ack) begin
        if (ackq.size() != 0) begin
          a = ackq.pop_front();
          chk("ack0", s_ack0, exp_ack && !a.own);
          chk("ack1", s_ack1, exp_ack && a.own);
          chk("ack_err", s_err, exp_ack && a.err);
        end else begin
          chk("spurious_ack", {s_ack0, s_ack1}, 0);
        end
      end else begin
        chk("err_no_ack", s_err, 0);
      end
      chk("busy", s_busy, (m_in_txn && cyc >= m_start) || (cyc < idle_from));
      chk("owner", s_owner, m_owner);
      chk("id_hold", s_id, m_id);
      chk("addr_hold", s_addr, m_addr);
      chk("data_hold", s_data, m_data);

      if (exp_ack) begin
        m_in_txn = 1'b0;
      end else if (m_in_txn && !m_decided && cyc > m_start) begin
        if (sccb_finish || (cyc - m_start == TO)) begin
          m_decided = 1'b1;
          m_ack     = cyc + 1;
          idle_from = m_ack + 1 + gapv;
          ackq.push_back('{own: m_owner, err: !sccb_finish});
        end
      end
      if (!m_in_txn && cyc >= idle_from && sccb_ready && (req0 || req1)) begin
        g         = (req0 && req1) ? !m_owner : req1;
        m_owner   = g;
        m_id      = g ? id1 : id0;
        m_addr    = g ? addr1 : addr0;
        m_data    = g ? data1 : data0;
        m_in_txn  = 1'b1;
        m_decided = 1'b0;
        m_start   = cyc + 1;
        txq.push_back('{id: m_id, addr: m_addr, data: m_data, own: m_owner});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    id0   = 7'($urandom);
    id1   = 7'($urandom);
    addr0 = 8'($urandom);
    addr1 = 8'($urandom);
    data0 = 8'($urandom);
    data1 = 8'($urandom);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (s_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_start: got no start_tx required one within 400 cycles");
    end
  endtask

  // Waits for start_tx, then pulses finish d cycles later (d<=0: never).
  task automatic serve(input int d);
    bit ok;
    wait_start(ok);
    if (ok && d > 0) begin
      repeat (d) tick();
      sccb_finish = 1'b1;
      tick();
      sccb_finish = 1'b0;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      rst         = ($urandom % 1500) == 0;
      req0        = ($urandom % 3) != 0;
      req1        = ($urandom % 3) != 0;
      sccb_ready  = ($urandom % 8) != 0;
      sccb_finish = ($urandom % 40) == 0;
      rand_fields();
      tick();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; sccb_finish = 1'b0;
    repeat (140) tick();
  endtask

  initial begin
    bit ok;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; sccb_ready = 1'b0; sccb_finish = 1'b0;
    id0 = '0; id1 = '0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single request, finish 40 cycles after start.
    req0 = 1'b1; id0 = 7'h21; addr0 = 8'h12; data0 = 8'h80; sccb_ready = 1'b1;
    wait_start(ok);
    if (ok) begin
      chk("first_fields", {s_id, s_addr, s_data}, {7'h21, 8'h12, 8'h80});
      tick();
      req0 = 1'b0;
      rand_fields();
      repeat (39) tick();
      sccb_finish = 1'b1;
      tick();
      sccb_finish = 1'b0;
      @(negedge clk);
      chk("first_ack0", {s_ack0, s_ack1, s_err}, 3'b100);
    end
    repeat (30) tick();

    // Both requesters held: grants alternate 0,1,0,1 from reset.
    pulse_rst();
    req0 = 1'b1; req1 = 1'b1; rand_fields();
    for (int k = 0; k < 4; k++) begin
      wait_start(ok);
      if (ok) begin
        chk("rr_owner", s_owner, k % 2);
        repeat (3 + $urandom_range(0, 5)) tick();
        sccb_finish = 1'b1;
        tick();
        sccb_finish = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (30) tick();

    // Timeout: ack1 and err exactly 101 cycles after start_tx.
    req1 = 1'b1;
    wait_start(ok);
    req1 = 1'b0;
    if (ok) begin
      repeat (100) tick();
      @(negedge clk);
      chk("pre_timeout", {s_ack1, s_err}, 2'b00);
      tick();
      @(negedge clk);
      chk("timeout_ack", {s_ack1, s_err}, 2'b11);
    end
    repeat (30) tick();

    // Finish on the timeout count: finish wins.
    req0 = 1'b1;
    wait_start(ok);
    req0 = 1'b0;
    if (ok) begin
      repeat (100) tick();
      sccb_finish = 1'b1;
      tick();
      sccb_finish = 1'b0;
      @(negedge clk);
      chk("coincident_ack", {s_ack0, s_err}, 2'b10);
    end
    repeat (30) tick();

    // Reset during WAIT_DONE, then a fresh request from requester 1.
    req0 = 1'b1;
    wait_start(ok);
    req0 = 1'b0;
    repeat (20) tick();
    pulse_rst();
    @(negedge clk);
    chk("rst_abort", {s_busy, s_ack0, s_ack1, s_err, s_owner}, 5'b00001);
    req1 = 1'b1;
    serve(10);
    req1 = 1'b0;
    repeat (30) tick();

    random_run(3000);

    // Zero-gap instance: ready gating and back-to-back grant after ACK.
    sel = 1'b1;
    pulse_rst();
    req1 = 1'b1; sccb_ready = 1'b0; rand_fields();
    repeat (10) tick();
    @(negedge clk);
    chk("ready_gate", s_busy, 0);
    sccb_ready = 1'b1;
    serve(5);
    @(negedge clk);
    chk("gap0_ack1", s_ack1, 1);
    tick();
    @(negedge clk);
    chk("gap0_regrant", {s_busy, s_start}, 2'b00);
    tick();
    @(negedge clk);
    chk("gap0_start", s_start, 1);
    req1 = 1'b0;
    repeat (3) tick();
    sccb_finish = 1'b1;
    tick();
    sccb_finish = 1'b0;
    repeat (10) tick();

    random_run(1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sccb_arbiter.md
SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16, meaning idle cycles enforced after each transaction (0 allowed).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning maximum cycles waited for sccb_finish (1..65535).
REQ-003 SHALL have port clk  in  1  FPGA clock, single clock domain.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0 / req1  in  1  transaction request from requester 0 / 1.
REQ-006 SHALL have ports id0 / id1  in  7, addr0 / addr1  in  8, data0 / data1  in  8  per-requester SCCB id, register address and write data.
REQ-007 SHALL have ports ack0 / ack1  out  1  one-cycle completion pulse to requester 0 / 1.
REQ-008 SHALL have port err  out  1  one-cycle pulse, coincident with ackN, flagging a timed-out transaction.
REQ-009 SHALL have ports sccb_ready  in  1 and sccb_finish  in  1  ready and finish_tx from the SCCB master.
REQ-010 SHALL have port start_tx  out  1  one-cycle start pulse to the SCCB master.
REQ-011 SHALL have ports id  out  7, addr  out  8, data_wr  out  8  registered fields driven to the SCCB master.
REQ-012 SHALL have ports busy  out  1 (state not IDLE) and owner  out  1 (index of last granted requester).

Function
REQ-013 SHALL implement FSM states IDLE, START, WAIT_DONE, ACK, GAP.
REQ-014 In IDLE, grant SHALL occur only when sccb_ready=1 and at least one reqN=1; otherwise remain in IDLE.
REQ-015 Single request: the requesting index SHALL be granted; both requesting: the index not equal to owner SHALL be granted (round-robin).
REQ-016 On grant, id/addr/data_wr SHALL latch the granted requester's fields, owner SHALL update, and the next state SHALL be START.
REQ-017 START SHALL last exactly one cycle with start_tx=1; start_tx SHALL be 0 in all other states; next state WAIT_DONE.
REQ-018 id/addr/data_wr SHALL hold stable from START until the next grant, regardless of requester input changes.
REQ-019 WAIT_DONE SHALL count cycles from 1; sccb_finish=1 SHALL go to ACK with err=0; count reaching TIMEOUT_CYCLES without finish SHALL go to ACK with err=1.
REQ-020 sccb_finish and timeout in the same cycle: finish SHALL win, err=0.
REQ-021 In ACK (one cycle), ack of owner SHALL be 1, the other ack 0, and err as decided in REQ-019.
REQ-022 After ACK: GAP_CYCLES=0 SHALL go to IDLE; otherwise GAP SHALL last exactly GAP_CYCLES cycles, then IDLE.
REQ-023 sccb_finish outside WAIT_DONE SHALL be ignored.
REQ-024 reqN dropped after grant SHALL NOT abort; ackN SHALL still pulse.
REQ-025 reqN dropped before grant SHALL cause no transaction.
REQ-026 A requester holding req high after its ack SHALL be re-arbitrated normally in the next IDLE.
REQ-027 Latency: grant in IDLE cycle T -> start_tx at T+1; finish seen at cycle M -> ack at M+1; next grant no earlier than M+2+GAP_CYCLES.
REQ-028 Cycle counters SHALL be 16 bits and SHALL clear on entering WAIT_DONE and GAP.

Reset
REQ-029 rst=1 SHALL force IDLE in the same clock edge, including mid-transaction, with no ack or err issued for the aborted transaction.
REQ-030 Reset values SHALL be: start_tx=0, ack0=0, ack1=0, err=0, busy=0, id=0, addr=0, data_wr=0, owner=1 (requester 0 wins the first tie), counters=0.

Verification
REQ-031 req0=1 (id 0x21, addr 0x12, data 0x80), sccb_ready=1, finish 40 cycles after start -> start_tx 1 cycle after grant, id/addr/data_wr=0x21/0x12/0x80, ack0 1 cycle after finish, err=0, busy low 16 cycles later.
REQ-032 req0 and req1 both held high for 4 transactions -> grants alternate 0,1,0,1; each ack goes only to its owner.
REQ-033 TIMEOUT_CYCLES=100, finish never asserted -> ackN and err both high exactly 101 cycles after start_tx.
REQ-034 Finish and timeout coincident (finish on count 100, TIMEOUT_CYCLES=100) -> ack=1, err=0.
REQ-035 rst pulsed during WAIT_DONE -> next cycle IDLE with all outputs at reset values, no ack; new req1 then served normally.
REQ-036 GAP_CYCLES=0, sccb_ready=0 while req1=1 -> no start_tx until sccb_ready=1; after ack1, the next grant occurs in the cycle immediately following ACK.
